func_result_buf_param: RTL and testbench
========================================

Name: func_result_buf_param

Overview:
- Generic result-buffer wrapper for the func_* operator family: owns write-side handshake, latency-matched address pipeline, per-entry completion tracking and a result RAM.
- Arithmetic/conversion core sits outside. Wrapper drives it with operand data and captures its result exactly LATENCY cycles later.
- Generalises the fixed single-semaphore scheme:
  - parametrised latency, depth and widths;
  - per-entry in-flight counters, so repeated writes to one address in flight report ready only after the last one retires;
  - write-first read bypass;
  - busy and in-flight status.

Parameters:
- LATENCY, 17, core latency in cycles from core_valid to core_result valid; legal range 1..64.
- ADDRS_WIDTH, 4, result RAM address width; DEPTH = 2**ADDRS_WIDTH.
- IN_WIDTH, 64, operand width.
- OUT_WIDTH, 378, result width; top 2 bits carry the exception code.
- CNT_WIDTH, clog2(LATENCY+1), per-entry in-flight counter width (derived, not overridden).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- wren  in  1  operand write strobe, one operation per cycle.
- wraddrs  in  ADDRS_WIDTH  destination result entry.
- wrdata  in  IN_WIDTH  operand.
- core_valid  out  1  combinational copy of wren.
- core_data  out  IN_WIDTH  combinational copy of wrdata.
- core_result  in  OUT_WIDTH  core output, sampled LATENCY cycles after core_valid.
- rden  in  1  read strobe.
- rdaddrs  in  ADDRS_WIDTH  read entry.
- rddata  out  OUT_WIDTH-2  result payload, registered.
- exceptCode  out  2  exception code of read entry, registered.
- ready  out  1  registered; 1 means rddata/exceptCode are final.
- busy  out  1  registered; 1 while any operation is in flight.

Behaviour:
- Reset values: ready=1, busy=0, rddata=0, exceptCode=0. Delay pipeline valids=0. All in-flight counters=0.
- RAM contents are not cleared by RESET.
- Delay line: {wren, wraddrs} shifted LATENCY stages. The stage-LATENCY output is retire_en/retire_addr.
- When retire_en=1, core_result is written to RAM[retire_addr] on that edge.
- Counters: cnt[a] increments on wren with wraddrs==a, and decrements on retire_en with retire_addr==a.
- Both events on the same address in one cycle: cnt unchanged.
- Max count is LATENCY, so no overflow. Decrement at 0 is impossible by construction; add an assertion for it.
- Read latency is 1 cycle. On an edge with rden=1:
  - {exceptCode, rddata} <= RAM[rdaddrs], write-first. If retire_addr==rdaddrs in the same cycle, the new core_result is returned.
  - ready <= (cnt_next[rdaddrs]==0), where cnt_next includes that cycle's increment and decrement.
- With rden=0: ready <= 1, and rddata/exceptCode hold.
- busy <= (total in-flight next != 0). Keep a running total counter of width clog2(LATENCY+1). Do not OR the counters.
- Write then read same address, same cycle: ready <= 0 (count becomes 1).
- Reset mid-operation: in-flight operations are discarded. No RAM write occurs for them after reset deasserts. ready=1 for all entries; stale RAM data is returned.
- Wrap-around: writes to any address pattern, including back-to-back to one address, are legal every cycle.

Decomposition:
- Shared package func_buf_pkg:
  - clog2 function;
  - exception code constants: NO_EXCPT=2'b00, UNDERFLOW_EXACT=2'b01, UNDERFLOW_INEXACT=2'b10, INEXACT=2'b11;
  - EXC_MSB/LSB field positions.
- Sub-module func_pipe_delay, parameters DEPTH_CYC and WIDTH: a reset-clearable valid+data shift register, instantiated for {wren, wraddrs}.
- RAM: the team's dual-port RAM primitive, with the bypass mux in this block.

Test Plan:
- LATENCY=17. Write addr 3 at cycle 0; rden addr 3 at cycles 1..18.
  - Expected: ready=0 through the read issued at cycle 16.
  - Read issued at cycle 17 (retire cycle) gives ready=1 with the core value via bypass.
  - busy falls after cycle 17.
- Three back-to-back writes to addr 5 (cycles 0,1,2) with distinct core results A, B, C.
  - Expected: ready stays 0 until the retire at cycle 19; data then equals C. cnt[5] follows 1,2,3,...,0.
- Write addr 7 and read addr 7 in the same cycle, with the entry previously idle.
  - Expected: next-cycle ready=0, rddata=old RAM contents.
- Core result with top bits 2'b11 and payload 0x1234 retires to addr 0, then addr 0 is read.
  - Expected: exceptCode=2'b11, rddata=0x1234, ready=1.
- Assert RESET for 1 cycle at cycle 8 after a write to addr 2 at cycle 0.
  - Expected: no RAM write at cycle 17, busy=0 after reset, read addr 2 gives ready=1 with pre-write contents.
- Parameter sweep LATENCY=1 and ADDRS_WIDTH=6, random writes every cycle with a reference scoreboard.
  - Expected: ready never 1 while the model count>0, and data always matches the model.

Source files
------------

// File: rtl/func_buf_pkg.sv
// Shared definitions for the func_* result-buffer wrappers: exception codes,
// exception field placement inside a core result word, and a constant clog2.
package func_buf_pkg;

    // Exception codes carried in the top two bits of every core result.
    localparam logic [1:0] NO_EXCPT          = 2'b00;
    localparam logic [1:0] UNDERFLOW_EXACT   = 2'b01;
    localparam logic [1:0] UNDERFLOW_INEXACT = 2'b10;
    localparam logic [1:0] INEXACT           = 2'b11;

    localparam int unsigned EXC_WIDTH = 2;

    // Ceiling log2, usable in constant expressions; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Exception field bit positions for a result word of the given width.
    function automatic int unsigned exc_msb(input int unsigned out_width);
        return out_width - 1;
    endfunction

    function automatic int unsigned exc_lsb(input int unsigned out_width);
        return out_width - EXC_WIDTH;
    endfunction

endpackage

// File: rtl/func_pipe_delay.sv
// Valid+data shift register of DEPTH_CYC stages. Only the valid bits are
// cleared by reset; data stages are don't-care while their valid is low.
module func_pipe_delay
    import func_buf_pkg::*;
#(
    parameter int unsigned DEPTH_CYC = 1,
    parameter int unsigned WIDTH     = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             shift_valid,
    input  logic [WIDTH-1:0] shift_data,
    output logic             tap_valid,
    output logic [WIDTH-1:0] tap_data
);

    logic [DEPTH_CYC-1:0] valid_q;
    logic [WIDTH-1:0]     data_q [DEPTH_CYC];

    // Valid chain, flushed by reset so in-flight operations are discarded.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= shift_valid;
            for (int i = 1; i < int'(DEPTH_CYC); i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Data chain, no reset needed.
    always_ff @(posedge CLK) begin
        data_q[0] <= shift_data;
        for (int i = 1; i < int'(DEPTH_CYC); i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign tap_valid = valid_q[DEPTH_CYC-1];
    assign tap_data  = data_q[DEPTH_CYC-1];

endmodule

// File: rtl/func_result_buf_param.sv
// Result buffer around an external fixed-latency func_* core: forwards
// operands to the core, retires its result into a RAM LATENCY cycles later,
// and tracks per-entry in-flight counts so a read reports ready only once
// every pending write to that entry has retired.
module func_result_buf_param
    import func_buf_pkg::*;
#(
    parameter int unsigned LATENCY     = 17,
    parameter int unsigned ADDRS_WIDTH = 4,
    parameter int unsigned IN_WIDTH    = 64,
    parameter int unsigned OUT_WIDTH   = 378
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   wren,
    input  logic [ADDRS_WIDTH-1:0] wraddrs,
    input  logic [IN_WIDTH-1:0]    wrdata,
    output logic                   core_valid,
    output logic [IN_WIDTH-1:0]    core_data,
    input  logic [OUT_WIDTH-1:0]   core_result,
    input  logic                   rden,
    input  logic [ADDRS_WIDTH-1:0] rdaddrs,
    output logic [OUT_WIDTH-3:0]   rddata,
    output logic [1:0]             exceptCode,
    output logic                   ready,
    output logic                   busy
);

    localparam int          DEPTH     = 2 ** ADDRS_WIDTH;
    localparam int unsigned CNT_WIDTH = clog2(LATENCY + 1);
    localparam int unsigned EMSB      = exc_msb(OUT_WIDTH);
    localparam int unsigned ELSB      = exc_lsb(OUT_WIDTH);

    logic                   retire_en;
    logic [ADDRS_WIDTH-1:0] retire_addr;

    logic [CNT_WIDTH-1:0]   cnt_q [DEPTH];
    logic [CNT_WIDTH-1:0]   cnt_d [DEPTH];
    logic [CNT_WIDTH-1:0]   total_q;
    logic [CNT_WIDTH-1:0]   total_d;

    logic [OUT_WIDTH-1:0]   ram_q [DEPTH];
    logic                   rd_hit;
    logic [OUT_WIDTH-1:0]   rd_word;

    logic [OUT_WIDTH-3:0]   rddata_q;
    logic [1:0]             exc_q;
    logic                   ready_q;
    logic                   busy_q;

    assign core_valid = wren;
    assign core_data  = wrdata;

    // Destination address travels alongside the operation through the core.
    func_pipe_delay #(
        .DEPTH_CYC (LATENCY),
        .WIDTH     (ADDRS_WIDTH)
    ) u_addr_delay (
        .CLK         (CLK),
        .RESET       (RESET),
        .shift_valid (wren),
        .shift_data  (wraddrs),
        .tap_valid   (retire_en),
        .tap_data    (retire_addr)
    );

    // Next in-flight counts; a same-cycle issue and retire on one entry cancel.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            cnt_d[a] = cnt_q[a];
            if (wren && (wraddrs == ADDRS_WIDTH'(a))) begin
                if (!(retire_en && (retire_addr == ADDRS_WIDTH'(a)))) begin
                    cnt_d[a] = cnt_q[a] + CNT_WIDTH'(1);
                end
            end else if (retire_en && (retire_addr == ADDRS_WIDTH'(a))) begin
                cnt_d[a] = cnt_q[a] - CNT_WIDTH'(1);
            end
        end
        total_d = total_q;
        if (wren && !retire_en) begin
            total_d = total_q + CNT_WIDTH'(1);
        end else if (!wren && retire_en) begin
            total_d = total_q - CNT_WIDTH'(1);
        end
    end

    // In-flight counters; pipeline depth bounds them at LATENCY.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int a = 0; a < DEPTH; a++) begin
                cnt_q[a] <= '0;
            end
            total_q <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                cnt_q[a] <= cnt_d[a];
            end
            total_q <= total_d;
        end
    end

    // A retiring entry must have been counted when it was issued.
    always_ff @(posedge CLK) begin
        if (!RESET && retire_en) begin
            assert (cnt_q[retire_addr] != '0);
        end
    end

    // Result RAM: written by the retiring operation, contents survive reset.
    always_ff @(posedge CLK) begin
        if (!RESET && retire_en) begin
            ram_q[retire_addr] <= core_result;
        end
    end

    // Write-first bypass so a read of the retiring entry sees the new result.
    assign rd_hit  = retire_en && (retire_addr == rdaddrs);
    assign rd_word = rd_hit ? core_result : ram_q[rdaddrs];

    // Registered read port and status.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rddata_q <= '0;
            exc_q    <= NO_EXCPT;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            if (rden) begin
                rddata_q <= rd_word[ELSB-1:0];
                exc_q    <= rd_word[EMSB:ELSB];
                ready_q  <= (cnt_d[rdaddrs] == '0);
            end else begin
                ready_q  <= 1'b1;
            end
            busy_q <= (total_d != '0);
        end
    end

    assign rddata     = rddata_q;
    assign exceptCode = exc_q;
    assign ready      = ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_func_result_buf_param.sv
// Bench for func_result_buf_param: a LATENCY=17/16-entry instance for directed
// scenarios and a LATENCY=1/64-entry instance for a random sweep, each driven
// by a behavioural core and checked against a transaction-level model.
module tb_func_result_buf_param;

    localparam int OW = 378;
    localparam int IW = 64;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic          wren1, rden1, core_valid1, ready1, busy1;
    logic [3:0]    wraddrs1, rdaddrs1;
    logic [IW-1:0] wrdata1, core_data1;
    logic [OW-1:0] core_result1;
    logic [OW-3:0] rddata1;
    logic [1:0]    exc1;

    logic          wren2, rden2, core_valid2, ready2, busy2;
    logic [5:0]    wraddrs2, rdaddrs2;
    logic [IW-1:0] wrdata2, core_data2;
    logic [OW-1:0] core_result2;
    logic [OW-3:0] rddata2;
    logic [1:0]    exc2;

    func_result_buf_param #(
        .LATENCY(17), .ADDRS_WIDTH(4), .IN_WIDTH(IW), .OUT_WIDTH(OW)
    ) u_dut1 (
        .CLK(CLK), .RESET(RESET), .wren(wren1), .wraddrs(wraddrs1), .wrdata(wrdata1),
        .core_valid(core_valid1), .core_data(core_data1), .core_result(core_result1),
        .rden(rden1), .rdaddrs(rdaddrs1), .rddata(rddata1), .exceptCode(exc1),
        .ready(ready1), .busy(busy1)
    );

    func_result_buf_param #(
        .LATENCY(1), .ADDRS_WIDTH(6), .IN_WIDTH(IW), .OUT_WIDTH(OW)
    ) u_dut2 (
        .CLK(CLK), .RESET(RESET), .wren(wren2), .wraddrs(wraddrs2), .wrdata(wrdata2),
        .core_valid(core_valid2), .core_data(core_data2), .core_result(core_result2),
        .rden(rden2), .rdaddrs(rdaddrs2), .rddata(rddata2), .exceptCode(exc2),
        .ready(ready2), .busy(busy2)
    );

    // Core function: top two operand bits become the exception code.
    function automatic logic [OW-1:0] core_fn(input logic [IW-1:0] d);
        return {d[63:62], 314'b0, d[61:0]};
    endfunction

    function automatic logic [IW-1:0] pre_data(input int a);
        return {a[1:0], 62'h0BAD_0000_0000} | IW'(a);
    endfunction

    // Behavioural cores with the matching latencies.
    logic [OW-1:0] cpipe1 [17];
    logic [OW-1:0] cpipe2;
    always @(posedge CLK) begin
        cpipe1[0] <= core_valid1 ? core_fn(core_data1) : '0;
        for (int i = 1; i < 17; i++) cpipe1[i] <= cpipe1[i-1];
        cpipe2 <= core_valid2 ? core_fn(core_data2) : '0;
    end
    assign core_result1 = cpipe1[16];
    assign core_result2 = cpipe2;

    int sel;
    logic          cur_ready, cur_busy;
    logic [OW-1:0] cur_word;
    logic [IW-1:0] cur_core_data;
    assign cur_ready     = (sel != 0) ? ready2 : ready1;
    assign cur_busy      = (sel != 0) ? busy2 : busy1;
    assign cur_word      = (sel != 0) ? {exc2, rddata2} : {exc1, rddata1};
    assign cur_core_data = (sel != 0) ? core_data2 : core_data1;

    typedef struct {
        int            rc;
        logic [5:0]    a;
        logic [OW-1:0] r;
    } op_t;

    typedef struct {
        logic          rdy;
        logic          bsy;
        logic [OW-1:0] word;
    } exp_t;

    op_t           infl[$];
    exp_t          sb[$];
    logic [OW-1:0] mram [64];
    int            mcnt [64];
    logic [OW-1:0] last_word;
    int            cyc, lat;
    int            checks, errors;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: model predicts, DUT output compared after the edge.
    task automatic step(input logic wr, input logic [5:0] wa, input logic [IW-1:0] wd,
                        input logic rd, input logic [5:0] ra, input string tag);
        op_t  r;
        op_t  w;
        exp_t e;
        logic ret;
        if (sel == 0) begin
            wren1 = wr; wraddrs1 = wa[3:0]; wrdata1 = wd; rden1 = rd; rdaddrs1 = ra[3:0];
        end else begin
            wren2 = wr; wraddrs2 = wa; wrdata2 = wd; rden2 = rd; rdaddrs2 = ra;
        end
        #1;
        if (wr) chk({tag, "_core_data"}, OW'(cur_core_data), OW'(wd));
        ret = 1'b0;
        if (infl.size() > 0 && infl[0].rc == cyc) begin
            ret = 1'b1;
            r   = infl.pop_front();
        end
        if (wr) begin
            w.rc = cyc + lat; w.a = wa; w.r = core_fn(wd);
            infl.push_back(w);
            mcnt[wa]++;
        end
        if (ret) mcnt[r.a]--;
        if (rd) begin
            last_word = (ret && r.a == ra) ? r.r : mram[ra];
            e.rdy     = (mcnt[ra] == 0);
        end else begin
            e.rdy     = 1'b1;
        end
        e.word = last_word;
        e.bsy  = (infl.size() != 0);
        sb.push_back(e);
        if (ret) mram[r.a] = r.r;
        @(posedge CLK);
        #1;
        cyc++;
        e = sb.pop_front();
        chk({tag, "_ready"}, OW'(cur_ready), OW'(e.rdy));
        chk({tag, "_busy"}, OW'(cur_busy), OW'(e.bsy));
        chk({tag, "_data"}, cur_word, e.word);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, '0, 1'b0, 6'd0, tag);
    endtask

    task automatic do_reset(input string tag);
        wren1 = 0; rden1 = 0; wren2 = 0; rden2 = 0;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        infl.delete();
        for (int i = 0; i < 64; i++) mcnt[i] = 0;
        last_word = '0;
        cyc++;
        chk({tag, "_rst_ready"}, OW'(cur_ready), OW'(1'b1));
        chk({tag, "_rst_busy"}, OW'(cur_busy), OW'(1'b0));
        chk({tag, "_rst_data"}, cur_word, '0);
    endtask

    logic [IW-1:0] d_a, d_b, d_c, d_x;

    initial begin
        checks = 0; errors = 0; sel = 0; lat = 17; cyc = 0;
        wren1 = 0; rden1 = 0; wraddrs1 = 0; rdaddrs1 = 0; wrdata1 = 0;
        wren2 = 0; rden2 = 0; wraddrs2 = 0; rdaddrs2 = 0; wrdata2 = 0;
        RESET = 1'b1;
        @(posedge CLK);
        do_reset("init");

        // Known contents in every entry.
        for (int a = 0; a < 16; a++) step(1'b1, 6'(a), pre_data(a), 1'b0, 6'd0, "fill1");
        idle(17, "fill1_drain");

        // Single write to 3, polled every cycle until it retires.
        d_a = 64'h1111_2222_3333_4444;
        step(1'b1, 6'd3, d_a, 1'b0, 6'd0, "t1_wr");
        for (int k = 1; k <= 18; k++) begin
            step(1'b0, 6'd0, '0, 1'b1, 6'd3, $sformatf("t1_rd%0d", k));
            chk($sformatf("t1_ready%0d", k), OW'(cur_ready), OW'(k >= 17));
            chk($sformatf("t1_busy%0d", k), OW'(cur_busy), OW'(k < 17));
            if (k >= 17) chk($sformatf("t1_val%0d", k), cur_word, core_fn(d_a));
        end

        // Three back-to-back writes to 5; ready only after the last retires.
        d_a = 64'h0000_0000_0000_0AAA;
        d_b = 64'h4000_0000_0000_0BBB;
        d_c = 64'h8000_0000_0000_0CCC;
        step(1'b1, 6'd5, d_a, 1'b1, 6'd5, "t2_w0");
        step(1'b1, 6'd5, d_b, 1'b1, 6'd5, "t2_w1");
        step(1'b1, 6'd5, d_c, 1'b1, 6'd5, "t2_w2");
        for (int k = 3; k <= 21; k++) begin
            step(1'b0, 6'd0, '0, 1'b1, 6'd5, $sformatf("t2_rd%0d", k));
            chk($sformatf("t2_ready%0d", k), OW'(cur_ready), OW'(k >= 19));
            if (k == 17) chk("t2_val_a", cur_word, core_fn(d_a));
            if (k == 19) chk("t2_val_c", cur_word, core_fn(d_c));
        end

        // Write and read of an idle entry in the same cycle.
        d_x = 64'h0123_4567_89AB_CDEF;
        step(1'b1, 6'd7, d_x, 1'b1, 6'd7, "t3");
        chk("t3_ready_lit", OW'(cur_ready), OW'(1'b0));
        chk("t3_old_lit", cur_word, core_fn(pre_data(7)));
        idle(17, "t3_drain");

        // Exception code field.
        d_x = {2'b11, 62'h1234};
        step(1'b1, 6'd0, d_x, 1'b0, 6'd0, "t4_wr");
        idle(17, "t4_wait");
        step(1'b0, 6'd0, '0, 1'b1, 6'd0, "t4_rd");
        chk("t4_exc_lit", OW'(exc1), OW'(2'b11));
        chk("t4_payload_lit", OW'(rddata1), OW'(16'h1234));
        chk("t4_ready_lit", OW'(ready1), OW'(1'b1));

        // Reset while a write is in flight: it must never land.
        d_x = 64'hFFFF_EEEE_DDDD_CCCC;
        step(1'b1, 6'd2, d_x, 1'b0, 6'd0, "t5_wr");
        idle(7, "t5_pre");
        do_reset("t5");
        idle(10, "t5_post");
        step(1'b0, 6'd0, '0, 1'b1, 6'd2, "t5_rd");
        chk("t5_stale_lit", cur_word, core_fn(pre_data(2)));
        chk("t5_ready_lit", OW'(cur_ready), OW'(1'b1));

        // Sweep on the LATENCY=1, 64-entry instance.
        sel = 1; lat = 1;
        do_reset("sweep");
        for (int a = 0; a < 64; a++) step(1'b1, 6'(a), pre_data(a), 1'b0, 6'd0, "fill2");
        idle(2, "fill2_drain");
        for (int i = 0; i < 400; i++) begin
            logic          wr, rd;
            logic [5:0]    wa, ra;
            logic [IW-1:0] wd;
            wr = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            wd = {$urandom, $urandom};
            step(wr, wa, wd, rd, ra, $sformatf("sw%0d", i));
        end
        idle(2, "sweep_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
